// File: rtl/lcd_picture_streamer.sv
// rtl/lcd_picture_streamer.sv - window setup plus frame-RAM pixel streaming to the LCD byte sender
// Define LCD_PIC_HMIRROR_EN to add the hmirror input (horizontally mirrored pixel addressing).
module lcd_picture_streamer #(
   parameter int ADDR_W  = 18,
   parameter int COORD_W = 16,
   parameter int RAM_LAT = 1,
   parameter int PIX_FMT = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [COORD_W-1:0] pic_w,
   input  logic [COORD_W-1:0] pic_h,
`ifdef LCD_PIC_HMIRROR_EN
   input  logic               hmirror,
`endif
   output logic               busy,
   output logic               done,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic               ram_rd_en,
   input  logic [23:0]        ram_data,
   output logic [7:0]         out_data,
   output logic               out_is_cmd,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam int         NB       = (PIX_FMT == 1) ? 3 : 2;
   localparam logic [2:0] NB_LAST  = 3'(NB - 1);
   localparam logic [2:0] LAT_LAST = 3'(RAM_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CASET, S_PASET, S_RAMWR, S_FETCH, S_WAIT_RAM, S_SEND, S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [COORD_W-1:0] x_q, y_q, w_q, h_q, col, row;
   logic [COORD_W-1:0] xe_c, ye_c;
   logic [ADDR_W-1:0]  row_base, pix_addr;
   logic [2:0]         byte_idx, lat_cnt;
   logic [23:0]        pix;
   logic [15:0]        xs16, xe16, ys16, ye16, s16, e16;
   logic [7:0]         pb0, pb1, pb2;
   logic               xfer, last_col, last_pix, zero_size;

   assign xe_c = x_q + w_q - COORD_W'(1);
   assign ye_c = y_q + h_q - COORD_W'(1);

   // Window coordinates always go out as 16-bit big-endian pairs.
   generate
      if (COORD_W >= 16) begin : g_trunc
         assign xs16 = x_q[15:0];
         assign xe16 = xe_c[15:0];
         assign ys16 = y_q[15:0];
         assign ye16 = ye_c[15:0];
      end else begin : g_ext
         assign xs16 = {{(16-COORD_W){1'b0}}, x_q};
         assign xe16 = {{(16-COORD_W){1'b0}}, xe_c};
         assign ys16 = {{(16-COORD_W){1'b0}}, y_q};
         assign ye16 = {{(16-COORD_W){1'b0}}, ye_c};
      end
   endgenerate

   generate
      if (PIX_FMT == 1) begin : g_666
         logic unused_pix;
         assign pb0 = {pix[23:18], 2'b00};
         assign pb1 = {pix[15:10], 2'b00};
         assign pb2 = {pix[7:2], 2'b00};
         assign unused_pix = ^{pix[17:16], pix[9:8], pix[1:0]};
      end else begin : g_565
         logic unused_pix;
         assign pb0 = {pix[23:19], pix[15:13]};
         assign pb1 = {pix[12:10], pix[7:3]};
         assign pb2 = 8'h00;
         assign unused_pix = ^{pix[18:16], pix[2:0]};
      end
   endgenerate

`ifdef LCD_PIC_HMIRROR_EN
   logic mir_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mir_q <= 1'b0;
      else if (state == S_IDLE && start)
         mir_q <= hmirror;
   end

   assign pix_addr = mir_q ? (row_base + ADDR_W'(w_q) - ADDR_W'(col) - ADDR_W'(1))
                           : (row_base + ADDR_W'(col));
`else
   assign pix_addr = row_base + ADDR_W'(col);
`endif

   assign zero_size = (pic_w == '0) || (pic_h == '0);
   assign last_col  = (col == w_q - COORD_W'(1));
   assign last_pix  = last_col && (row == h_q - COORD_W'(1));

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign ram_rd_en = (state == S_FETCH);
   assign ram_addr  = ram_rd_en ? pix_addr : '0;
   assign out_valid = (state == S_CASET) || (state == S_PASET) ||
                      (state == S_RAMWR) || (state == S_SEND);
   assign xfer      = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (start) state_nxt = zero_size ? S_DONE : S_CASET;
         S_CASET:    if (xfer && byte_idx == 3'd4) state_nxt = S_PASET;
         S_PASET:    if (xfer && byte_idx == 3'd4) state_nxt = S_RAMWR;
         S_RAMWR:    if (xfer) state_nxt = S_FETCH;
         S_FETCH:    state_nxt = S_WAIT_RAM;
         S_WAIT_RAM: if (lat_cnt == LAT_LAST) state_nxt = S_SEND;
         S_SEND:     if (xfer && byte_idx == NB_LAST) state_nxt = last_pix ? S_DONE : S_FETCH;
         S_DONE:     state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   assign s16 = (state == S_CASET) ? xs16 : ys16;
   assign e16 = (state == S_CASET) ? xe16 : ye16;

   always_comb begin
      out_data   = 8'h00;
      out_is_cmd = 1'b0;
      case (state)
         S_CASET, S_PASET: begin
            case (byte_idx)
               3'd0: begin
                  out_is_cmd = 1'b1;
                  out_data   = (state == S_CASET) ? 8'h2A : 8'h2B;
               end
               3'd1:    out_data = s16[15:8];
               3'd2:    out_data = s16[7:0];
               3'd3:    out_data = e16[15:8];
               default: out_data = e16[7:0];
            endcase
         end
         S_RAMWR: begin
            out_is_cmd = 1'b1;
            out_data   = 8'h2C;
         end
         S_SEND:  out_data = (byte_idx == 3'd0) ? pb0 : (byte_idx == 3'd1) ? pb1 : pb2;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q      <= '0;
         y_q      <= '0;
         w_q      <= '0;
         h_q      <= '0;
         col      <= '0;
         row      <= '0;
         row_base <= '0;
         byte_idx <= '0;
         lat_cnt  <= '0;
         pix      <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               x_q      <= x;
               y_q      <= y;
               w_q      <= pic_w;
               h_q      <= pic_h;
               col      <= '0;
               row      <= '0;
               row_base <= '0;
               byte_idx <= '0;
               lat_cnt  <= '0;
            end
            S_CASET, S_PASET, S_RAMWR: if (xfer)
               byte_idx <= (state_nxt == state) ? byte_idx + 3'd1 : 3'd0;
            S_WAIT_RAM: begin
               if (lat_cnt == LAT_LAST) begin
                  lat_cnt <= '0;
                  pix     <= ram_data;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            S_SEND: if (xfer) begin
               if (byte_idx == NB_LAST) begin
                  byte_idx <= '0;
                  // Row base tracks row*pic_w so no multiplier is needed.
                  if (!last_pix) begin
                     if (last_col) begin
                        col      <= '0;
                        row      <= row + COORD_W'(1);
                        row_base <= row_base + ADDR_W'(w_q);
                     end else begin
                        col <= col + COORD_W'(1);
                     end
                  end
               end else begin
                  byte_idx <= byte_idx + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_picture_streamer.sv
// tb/tb_lcd_picture_streamer.sv - randomized model-checked bench for lcd_picture_streamer
// Two instances: RGB565 with RAM_LAT=1 and RGB666 with RAM_LAT=3, sharing stimulus and out_ready.
module tb_lcd_picture_streamer;

   localparam int AW = 18;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] x = '0, y = '0, pic_w = '0, pic_h = '0;
   logic        out_ready = 1'b1;
`ifdef LCD_PIC_HMIRROR_EN
   logic        hmirror = 1'b0;
`endif

   logic          busy[2], done[2], ram_rd_en[2], out_is_cmd[2], out_valid[2];
   logic [AW-1:0] ram_addr[2];
   logic [23:0]   ram_data[2];
   logic [7:0]    out_data[2];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit ready_rand = 1'b0;
   int ram_mode = 0;
   bit fin_req = 1'b0;

   bit          active[2], done_due[2], hold[2], prev_valid[2], rd_seen[2];
   logic [7:0]  hold_data[2];
   logic        hold_cmd[2];
   int          rd_cyc[2], rd_cnt[2], act_cyc[2];
   int unsigned rd_a[2];
   logic [8:0]  exp_b[2][$];
   int unsigned exp_a[2][$];
   logic [8:0]  lit[11];

   always #5 clk = ~clk;

   lcd_picture_streamer #(.ADDR_W(AW), .COORD_W(16), .RAM_LAT(1), .PIX_FMT(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .pic_w(pic_w), .pic_h(pic_h),
`ifdef LCD_PIC_HMIRROR_EN
      .hmirror(hmirror),
`endif
      .busy(busy[0]), .done(done[0]), .ram_addr(ram_addr[0]), .ram_rd_en(ram_rd_en[0]),
      .ram_data(ram_data[0]), .out_data(out_data[0]), .out_is_cmd(out_is_cmd[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready)
   );

   lcd_picture_streamer #(.ADDR_W(AW), .COORD_W(16), .RAM_LAT(3), .PIX_FMT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .pic_w(pic_w), .pic_h(pic_h),
`ifdef LCD_PIC_HMIRROR_EN
      .hmirror(hmirror),
`endif
      .busy(busy[1]), .done(done[1]), .ram_addr(ram_addr[1]), .ram_rd_en(ram_rd_en[1]),
      .ram_data(ram_data[1]), .out_data(out_data[1]), .out_is_cmd(out_is_cmd[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready)
   );

   function automatic int lat_of(int g);
      return (g == 0) ? 1 : 3;
   endfunction

   function automatic int fmt_of(int g);
      return (g == 0) ? 0 : 1;
   endfunction

   function automatic logic [23:0] mem_word(int unsigned a, int mode);
      logic [31:0] h;
      if (mode == 1) return 24'hF8FCF8;
      h = a * 32'h9E3779B1 + 32'h01234567;
      return h[31:8];
   endfunction

   function automatic logic [7:0] pix_byte(int fmt, logic [23:0] d, int k);
      int r, g, b;
      r = int'(d[23:16]);
      g = int'(d[15:8]);
      b = int'(d[7:0]);
      if (fmt == 0)
         return (k == 0) ? 8'(((r >> 3) << 3) | (g >> 5)) : 8'((((g >> 2) & 7) << 5) | (b >> 3));
      return 8'(((k == 0) ? r : (k == 1) ? g : b) & 'hFC);
   endfunction

   function automatic logic [8:0] hdr_byte(int i, int xx, int yy, int ww, int hh);
      int s, e, j;
      if (i == 10) return 9'h12C;
      s = (i < 5) ? xx : yy;
      e = (s + ((i < 5) ? ww : hh) - 1) & 'hFFFF;
      j = i % 5;
      case (j)
         0:       return (i == 0) ? 9'h12A : 9'h12B;
         1:       return {1'b0, 8'(s >> 8)};
         2:       return {1'b0, 8'(s & 'hFF)};
         3:       return {1'b0, 8'(e >> 8)};
         default: return {1'b0, 8'(e & 'hFF)};
      endcase
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic flag(string name, logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got %0h with nothing expected at cycle %0d", name, act, cyc);
   endtask

   // Single compare process: owns the reference model, the RAM model and every comparison.
   initial begin
      bit          ending, mir_now;
      logic [8:0]  e;
      int unsigned a;
      int          xx, yy, ww, hh;
      ram_data[0] = '0;
      ram_data[1] = '0;
      lit = '{9'h12A, 9'h000, 9'h00A, 9'h000, 9'h00B, 9'h12B, 9'h000, 9'h014, 9'h000, 9'h015, 9'h12C};
      forever begin
         @(negedge clk);
         cyc++;
         if (cyc == 2) begin
            for (int i = 0; i < 11; i++) chk("model_hdr", 32'(hdr_byte(i, 10, 20, 2, 2)), 32'(lit[i]));
            chk("model_565_b0", 32'(pix_byte(0, 24'hF8FCF8, 0)), 32'hFF);
            chk("model_565_b1", 32'(pix_byte(0, 24'hF8FCF8, 1)), 32'hFF);
            chk("model_666_b0", 32'(pix_byte(1, 24'hF8FCF8, 0)), 32'hF8);
            chk("model_666_b1", 32'(pix_byte(1, 24'hF8FCF8, 1)), 32'hFC);
            chk("model_666_b2", 32'(pix_byte(1, 24'hF8FCF8, 2)), 32'hF8);
         end
         for (int g = 0; g < 2; g++) begin
            if (rst) begin
               chk("reset_outputs", 32'({busy[g], done[g], ram_rd_en[g], out_valid[g], out_is_cmd[g],
                                         ram_addr[g], out_data[g]}), 32'h0);
               exp_b[g].delete();
               exp_a[g].delete();
               active[g] = 0; done_due[g] = 0; hold[g] = 0; prev_valid[g] = 0;
               rd_seen[g] = 0; rd_cnt[g] = 0; act_cyc[g] = 0;
               continue;
            end
            chk("done", 32'(done[g]), 32'(done_due[g]));
            chk("busy", 32'(busy[g]), 32'(active[g]));
            ending = done_due[g];
            done_due[g] = 0;
            if (hold[g])
               chk("hold_stable", 32'({out_valid[g], out_is_cmd[g], out_data[g]}),
                   32'({1'b1, hold_cmd[g], hold_data[g]}));
            if (out_valid[g] && !prev_valid[g] && rd_seen[g]) begin
               chk("ram_latency", 32'(cyc - rd_cyc[g]), 32'(lat_of(g) + 1));
               rd_seen[g] = 0;
            end
            if (out_valid[g] && out_ready) begin
               if (exp_b[g].size() == 0) begin
                  flag("extra_byte", 32'({out_is_cmd[g], out_data[g]}));
               end else begin
                  e = exp_b[g].pop_front();
                  chk(g == 0 ? "byte_565" : "byte_666", 32'({out_is_cmd[g], out_data[g]}), 32'(e));
                  if (exp_b[g].size() == 0) done_due[g] = 1;
               end
            end
            // RAM model: data is correct only in the cycle exactly RAM_LAT after the strobe.
            if (rd_cnt[g] > 0) rd_cnt[g]--;
            ram_data[g] = (rd_cnt[g] == 0 && rd_seen[g] && cyc == rd_cyc[g] + lat_of(g))
                          ? mem_word(rd_a[g], ram_mode) : 24'($urandom);
            if (ram_rd_en[g]) begin
               if (exp_a[g].size() == 0) begin
                  flag("extra_ram_read", 32'(ram_addr[g]));
               end else begin
                  a = exp_a[g].pop_front();
                  chk("ram_addr", 32'(ram_addr[g]), a);
               end
               rd_seen[g] = 1;
               rd_cyc[g] = cyc;
               rd_cnt[g] = lat_of(g);
               rd_a[g] = 32'(ram_addr[g]);
            end
            if (active[g] && ++act_cyc[g] > 3000) begin
               flag("frame_timeout", 32'(exp_b[g].size()));
               exp_b[g].delete();
               exp_a[g].delete();
               ending = 1;
            end
            hold[g] = out_valid[g] && !out_ready;
            hold_data[g] = out_data[g];
            hold_cmd[g] = out_is_cmd[g];
            prev_valid[g] = out_valid[g];
            if (ending) active[g] = 0;
            if (!active[g] && start) begin
`ifdef LCD_PIC_HMIRROR_EN
               mir_now = hmirror;
`else
               mir_now = 0;
`endif
               xx = int'(x); yy = int'(y); ww = int'(pic_w); hh = int'(pic_h);
               exp_b[g].delete();
               exp_a[g].delete();
               if (ww != 0 && hh != 0) begin
                  for (int i = 0; i < 11; i++) exp_b[g].push_back(hdr_byte(i, xx, yy, ww, hh));
                  for (int r = 0; r < hh; r++)
                     for (int c = 0; c < ww; c++) begin
                        a = 32'(r * ww + (mir_now ? ww - 1 - c : c)) & ((32'd1 << AW) - 1);
                        exp_a[g].push_back(a);
                        for (int k = 0; k < 2 + fmt_of(g); k++)
                           exp_b[g].push_back({1'b0, pix_byte(fmt_of(g), mem_word(a, ram_mode), k)});
                     end
               end else begin
                  done_due[g] = 1;
               end
               active[g] = 1;
               act_cyc[g] = 0;
            end
         end
         if (fin_req) begin
            for (int g = 0; g < 2; g++) begin
               chk("bytes_left", 32'(exp_b[g].size()), 0);
               chk("reads_left", 32'(exp_a[g].size()), 0);
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic start_frame(int xx, int yy, int ww, int hh);
      @(posedge clk);
      #1;
      x = 16'(xx); y = 16'(yy); pic_w = 16'(ww); pic_h = 16'(hh);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      x = 16'($urandom); y = 16'($urandom); pic_w = 16'($urandom); pic_h = 16'($urandom);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 8000; i++) begin
         @(negedge clk);
         #1;
         if (!active[0] && !active[1]) return;
      end
      $display("FAIL wait_idle: model still active after 8000 cycles");
      $fatal(1, "bench stalled");
   endtask

   task automatic frame(int xx, int yy, int ww, int hh);
      start_frame(xx, yy, ww, hh);
      wait_idle();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      frame(10, 20, 2, 2);
      ram_mode = 1;
      frame(0, 0, 1, 1);
      ram_mode = 0;
      ready_rand = 1'b1;
      frame(10, 20, 2, 2);
      frame(5, 6, 3, 1);
      ready_rand = 1'b0;
      frame(7, 7, 0, 5);
      frame(7, 7, 3, 0);
      start_frame(3, 4, 2, 1);
      repeat (4) @(posedge clk);
      #1;
      x = 16'd1; y = 16'd1; pic_w = 16'd1; pic_h = 16'd1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle();
      ready_rand = 1'b1;
      for (int i = 0; i < 10; i++) begin
         frame(($urandom_range(0, 1) != 0) ? int'($urandom_range(65530, 65535)) : int'($urandom_range(0, 400)),
               ($urandom_range(0, 1) != 0) ? int'($urandom_range(65532, 65535)) : int'($urandom_range(0, 300)),
               int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
      end
      start_frame(0, 0, 4, 3);
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      frame(2, 3, 2, 1);
`ifdef LCD_PIC_HMIRROR_EN
      hmirror = 1'b1;
      frame(0, 0, 4, 2);
      hmirror = 1'b0;
`endif
      @(posedge clk);
      #1;
      fin_req = 1'b1;
      @(negedge clk);
      #1;
      fin_req = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
